// File: rtl/roberto_scan.sv
`default_nettype none
// ============================================================================
//  Module   : roberto_scan
//  Purpose  : Sequential ultrasonic range scanner. On a start pulse it fires
//             each sensor's trigger in turn, measures the width of its echo
//             (in clocks), and ships three bytes per channel to a serial
//             transmitter: {timeout, 4'b0, channel}, result[15:8], result[7:0].
//  Ports    : clock      - system clock, all logic on the rising edge
//             reset      - synchronous, active-low
//             ligar      - one-clock start pulse (accepted only when idle)
//             echo       - asynchronous echo lines, one per channel
//             trigger    - trigger pulses, one per channel
//             tx_dado    - byte to transmitter (held until tx_pronto)
//             tx_partida - one-clock transmitter start strobe
//             tx_pronto  - one-clock transmitter done strobe
//             varrendo   - high while a sweep is in progress
//             db_estado  - current state code
//             db_canal   - channel under service
//  Options  : ROBERTO_SCAN_CONTINUO_EN - when defined, sweeps repeat forever
//             with a PAUSE_CYC gap; otherwise one sweep per ligar.
//  Revision : 1.0 - initial release
// ============================================================================
module roberto_scan #(
  parameter int N_CH        = 3,
  parameter int MW          = 16,
  parameter int TRIG_CYC    = 500,
  parameter int TIMEOUT_CYC = 1500000,
  parameter int PAUSE_CYC   = 2500000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ligar,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] trigger,
  output logic [7:0]      tx_dado,
  output logic            tx_partida,
  input  logic            tx_pronto,
  output logic            varrendo,
  output logic [3:0]      db_estado,
  output logic [2:0]      db_canal
);

  localparam logic [3:0] INICIAL    = 4'd0;
  localparam logic [3:0] DISPARA    = 4'd1;
  localparam logic [3:0] ESPERA_ECO = 4'd2;
  localparam logic [3:0] MEDE       = 4'd3;
  localparam logic [3:0] ENVIA_ID   = 4'd4;
  localparam logic [3:0] ESPERA_ID  = 4'd5;
  localparam logic [3:0] ENVIA_H    = 4'd6;
  localparam logic [3:0] ESPERA_H   = 4'd7;
  localparam logic [3:0] ENVIA_L    = 4'd8;
  localparam logic [3:0] ESPERA_L   = 4'd9;
  localparam logic [3:0] PROXIMO    = 4'd10;
  localparam logic [3:0] PAUSA      = 4'd11;

  // One shared phase timer serves the trigger, echo-wait, echo-high and
  // pause phases, so it is sized for the longest of them.
  localparam int MAX_A   = (TRIG_CYC > TIMEOUT_CYC) ? TRIG_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_A > PAUSE_CYC) ? MAX_A : PAUSE_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
`ifdef ROBERTO_SCAN_CONTINUO_EN
  localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_CYC - 1);
`endif
  localparam logic [MW-1:0] CNT_MAX = '1;
  localparam logic [MW-1:0] CNT_ONE = MW'(1);
  localparam logic [2:0]    LAST_CH = 3'(N_CH - 1);

  logic [3:0]      state_q,    state_d;
  logic [2:0]      canal_q,    canal_d;
  logic [TW-1:0]   timer_q,    timer_d;
  logic [MW-1:0]   cnt_q,      cnt_d;
  logic [15:0]     result_q,   result_d;
  logic            flag_q,     flag_d;
  logic [N_CH-1:0] sync1_q,    sync1_d;
  logic [N_CH-1:0] sync2_q,    sync2_d;
  logic [N_CH-1:0] prev_q,     prev_d;
  logic [N_CH-1:0] trigger_q,  trigger_d;
  logic [7:0]      tx_dado_q,  tx_dado_d;
  logic            tx_part_q,  tx_part_d;
  logic            varrendo_q, varrendo_d;

  logic [N_CH-1:0] sel_cur;
  logic [N_CH-1:0] sel_next;
  logic            echo_sel;
  logic            echo_rise;

  // Channel select and echo edge detect for the channel under service.
  // prev_q lags sync2_q by one clock; a line already high on entry to
  // ESPERA_ECO therefore shows no edge until it drops and rises again.
  always_comb begin
    sel_cur = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_cur[i] = (canal_q == 3'(i));
    end
    echo_sel  = |(sync2_q & sel_cur);
    echo_rise = echo_sel & ~(|(prev_q & sel_cur));
  end

  always_comb begin
    state_d  = state_q;
    canal_d  = canal_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;
    sync1_d  = echo;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;

    case (state_q)
      INICIAL: begin
        if (ligar) begin
          state_d = DISPARA;
          canal_d = 3'd0;
          timer_d = '0;
        end
      end
      DISPARA: begin
        if (timer_q == TRIG_LAST) begin
          state_d = ESPERA_ECO;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ESPERA_ECO: begin
        if (echo_rise) begin
          // The sample carrying the edge is the first high clock.
          state_d = MEDE;
          timer_d = TIMER_ONE;
          cnt_d   = CNT_ONE;
        end else if (timer_q == TMO_LAST) begin
          state_d  = ENVIA_ID;
          flag_d   = 1'b1;
          result_d = 16'(CNT_MAX);
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      MEDE: begin
        if (!echo_sel) begin
          state_d  = ENVIA_ID;
          flag_d   = 1'b0;
          result_d = 16'(cnt_q);
        end else if (timer_q == TMO_LAST) begin
          state_d  = ENVIA_ID;
          flag_d   = 1'b1;
          result_d = 16'(CNT_MAX);
        end else begin
          timer_d = timer_q + TIMER_ONE;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ENVIA_ID:  state_d = ESPERA_ID;
      ESPERA_ID: if (tx_pronto) state_d = ENVIA_H;
      ENVIA_H:   state_d = ESPERA_H;
      ESPERA_H:  if (tx_pronto) state_d = ENVIA_L;
      ENVIA_L:   state_d = ESPERA_L;
      ESPERA_L:  if (tx_pronto) state_d = PROXIMO;
      PROXIMO: begin
        timer_d = '0;
        if (canal_q == LAST_CH) begin
          state_d = PAUSA;
          canal_d = 3'd0;
        end else begin
          state_d = DISPARA;
          canal_d = canal_q + 3'd1;
        end
      end
      PAUSA: begin
`ifdef ROBERTO_SCAN_CONTINUO_EN
        if (timer_q == PAUSE_LAST) begin
          state_d = DISPARA;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
`else
        state_d = INICIAL;
`endif
      end
      default: state_d = INICIAL;
    endcase

    // Outputs are registered from the next state so they line up exactly
    // with db_estado and never glitch.
    sel_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_next[i] = (canal_d == 3'(i));
    end
    trigger_d  = (state_d == DISPARA) ? sel_next : '0;
    tx_part_d  = (state_d == ENVIA_ID) || (state_d == ENVIA_H) || (state_d == ENVIA_L);
    varrendo_d = (state_d != INICIAL);

    tx_dado_d = tx_dado_q;
    case (state_d)
      ENVIA_ID: tx_dado_d = {flag_d, 4'b0000, canal_d};
      ENVIA_H:  tx_dado_d = result_d[15:8];
      ENVIA_L:  tx_dado_d = result_d[7:0];
      default:  tx_dado_d = tx_dado_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= INICIAL;
      canal_q    <= 3'd0;
      timer_q    <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      flag_q     <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      trigger_q  <= '0;
      tx_dado_q  <= '0;
      tx_part_q  <= 1'b0;
      varrendo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      canal_q    <= canal_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      flag_q     <= flag_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      trigger_q  <= trigger_d;
      tx_dado_q  <= tx_dado_d;
      tx_part_q  <= tx_part_d;
      varrendo_q <= varrendo_d;
    end
  end

  assign trigger    = trigger_q;
  assign tx_dado    = tx_dado_q;
  assign tx_partida = tx_part_q;
  assign varrendo   = varrendo_q;
  assign db_estado  = state_q;
  assign db_canal   = canal_q;

endmodule
`default_nettype wire

// File: tb/tb_roberto_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_roberto_scan
//  Purpose  : Self-checking bench for roberto_scan. Main instance: 3 channels,
//             16-bit measurement; second instance: 1 channel, 8-bit
//             measurement for saturation. Expected bytes come from a
//             per-channel model (echo width -> ID/high/low bytes).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_roberto_scan;

  localparam int N_CH  = 3;
  localparam int MW    = 16;
  localparam int TRIG  = 50;
  localparam int TMO   = 5000;
  localparam int PAUSE = 100;

  logic            clock = 1'b0;
  logic            reset;
  logic            ligar;
  logic [N_CH-1:0] echo;
  logic [N_CH-1:0] trigger;
  logic [7:0]      tx_dado;
  logic            tx_partida;
  logic            tx_pronto;
  logic            varrendo;
  logic [3:0]      db_estado;
  logic [2:0]      db_canal;

  logic       s_ligar;
  logic [0:0] s_echo;
  logic [0:0] s_trigger;
  logic [7:0] s_tx_dado;
  logic       s_tx_partida;
  logic       s_tx_pronto;
  logic       s_varrendo;
  logic [3:0] s_db_estado;
  logic [2:0] s_db_canal;
  logic       s_prev;

  always #5 clock = ~clock;

  roberto_scan #(.N_CH(N_CH), .MW(MW), .TRIG_CYC(TRIG), .TIMEOUT_CYC(TMO), .PAUSE_CYC(PAUSE)) u_dut (
    .clock(clock), .reset(reset), .ligar(ligar), .echo(echo), .trigger(trigger),
    .tx_dado(tx_dado), .tx_partida(tx_partida), .tx_pronto(tx_pronto),
    .varrendo(varrendo), .db_estado(db_estado), .db_canal(db_canal));

  roberto_scan #(.N_CH(1), .MW(8), .TRIG_CYC(TRIG), .TIMEOUT_CYC(TMO), .PAUSE_CYC(PAUSE)) u_sat (
    .clock(clock), .reset(reset), .ligar(s_ligar), .echo(s_echo), .trigger(s_trigger),
    .tx_dado(s_tx_dado), .tx_partida(s_tx_partida), .tx_pronto(s_tx_pronto),
    .varrendo(s_varrendo), .db_estado(s_db_estado), .db_canal(s_db_canal));

  int         n_pass  = 0;
  int         n_total = 0;
  int         proto_err = 0;
  bit         pending = 0;
  int         resp_dly = 10;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] sat_q[$];
  int         trig_len[N_CH];
  int         trig_bad[N_CH];

  // Byte monitor and strobe-protocol watcher for the main instance.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      pending = 0;
    end else begin
      if (tx_pronto) pending = 0;
      if (tx_partida) begin
        if (pending) proto_err++;
        pending = 1;
        got_q.push_back(tx_dado);
      end
    end
  end

  // Transmitter model: answers each strobe resp_dly clocks later.
  initial begin
    tx_pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && tx_partida) begin
        repeat (resp_dly) @(posedge clock);
        #1 tx_pronto = 1'b1;
        @(posedge clock);
        #1 tx_pronto = 1'b0;
      end
    end
  end

  // Fast transmitter model and byte monitor for the saturation instance.
  initial begin
    s_tx_pronto = 1'b0;
    s_prev      = 1'b0;
    forever begin
      @(negedge clock);
      s_tx_pronto = s_prev;
      s_prev      = s_tx_partida;
      if (reset && s_tx_partida) sat_q.push_back(s_tx_dado);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: bytes one channel produces for a given echo width
  // (0 = never echoes).
  task automatic add_expected(input int ch, input int w, input int mw);
    int r;
    int maxv;
    logic [7:0] id;
    maxv = (1 << mw) - 1;
    id   = 8'(ch);
    if (w == 0) begin
      exp_q.push_back(8'h80 | id);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
    end else begin
      r = (w > maxv) ? maxv : w;
      exp_q.push_back(id);
      exp_q.push_back(8'((r >> 8) & 255));
      exp_q.push_back(8'(r & 255));
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; ligar = 1'b0; echo = '0; s_ligar = 1'b0; s_echo = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    got_q.delete(); exp_q.delete(); sat_q.delete();
    proto_err = 0;
    @(negedge clock);
  endtask

  task automatic pulse_ligar();
    @(negedge clock);
    ligar = 1'b1;
    @(negedge clock);
    ligar = 1'b0;
  endtask

  // Waits for the channel's trigger, measures it, then drives its echo.
  task automatic serve_channel(input int ch, input int w, input bit pre, input bit mid_ligar);
    int k;
    int hi;
    int bad;
    logic [N_CH-1:0] mask;
    mask = '0;
    mask[ch] = 1'b1;
    k = 0;
    while (trigger[ch] !== 1'b1 && k < 20000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 20000) begin
      n_total++;
      $display("FAIL trig_wait ch%0d: no trigger after %0d clocks", ch, k);
      return;
    end
    if (pre) echo[ch] = 1'b1;
    hi = 0; bad = 0;
    while (trigger[ch] === 1'b1 && hi < 4 * TRIG) begin
      if (trigger !== mask) bad++;
      hi++;
      @(negedge clock);
    end
    trig_len[ch] = hi;
    trig_bad[ch] = bad;
    if (pre) begin
      repeat (20) @(negedge clock);
      echo[ch] = 1'b0;
      repeat (10) @(negedge clock);
    end else begin
      repeat ($urandom_range(40, 3)) @(negedge clock);
    end
    if (w > 0) begin
      echo[ch] = 1'b1;
      for (int i = 0; i < w; i++) begin
        ligar = (mid_ligar && i == w / 2);
        @(negedge clock);
      end
      ligar = 1'b0;
      echo[ch] = 1'b0;
    end
  endtask

  task automatic run_sweep(input int w[N_CH], input bit pre0, input int mid_ch);
    int k;
    for (int c = 0; c < N_CH; c++) add_expected(c, w[c], MW);
    pulse_ligar();
    for (int c = 0; c < N_CH; c++) serve_channel(c, w[c], (c == 0) && pre0, c == mid_ch);
    k = 0;
    while (got_q.size() < exp_q.size() && k < 20000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 20000) begin
      n_total++;
      $display("FAIL byte_wait: got %0d bytes, need %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ligar = 1'b0; echo = '0; s_ligar = 1'b0; s_echo = '0;
    repeat (4) @(negedge clock);
    n_total++; if (trigger !== '0) $display("FAIL rst_trigger: got %0h need 0", trigger); else n_pass++;
    n_total++; if (tx_partida !== 1'b0) $display("FAIL rst_partida: got %0b need 0", tx_partida); else n_pass++;
    n_total++; if (tx_dado !== 8'h00) $display("FAIL rst_dado: got %0h need 00", tx_dado); else n_pass++;
    n_total++; if (varrendo !== 1'b0) $display("FAIL rst_varrendo: got %0b need 0", varrendo); else n_pass++;
    n_total++; if (db_estado !== 4'd0) $display("FAIL rst_estado: got %0d need 0", db_estado); else n_pass++;
    n_total++; if (db_canal !== 3'd0) $display("FAIL rst_canal: got %0d need 0", db_canal); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_sweep_fixed();
    int w[N_CH] = '{1000, 2000, 3000};
    do_reset();
    resp_dly = 10;
    run_sweep(w, 1'b0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL fixed_byte%0d: got %0h need %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    n_total++; if (proto_err !== 0) $display("FAIL fixed_proto: %0d double strobes, need 0", proto_err); else n_pass++;
  endtask

  task automatic test_timeout();
    int w[N_CH] = '{700, 0, 1500};
    do_reset();
    resp_dly = 10;
    run_sweep(w, 1'b0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL timeout_byte%0d: got %0h need %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ligar_in_mede();
    int w[N_CH] = '{400, 800, 600};
    do_reset();
    resp_dly = 5;
    run_sweep(w, 1'b0, 1);
    for (int c = 0; c < N_CH; c++) begin
      n_total++; if (trig_len[c] !== TRIG) $display("FAIL trig_len ch%0d: got %0d need %0d", c, trig_len[c], TRIG); else n_pass++;
      n_total++; if (trig_bad[c] !== 0) $display("FAIL trig_bits ch%0d: %0d clocks with wrong bits, need 0", c, trig_bad[c]); else n_pass++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL mede_ligar_byte%0d: got %0h need %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_echo_pre();
    int w[N_CH] = '{400, 200, 300};
    do_reset();
    resp_dly = 3;
    run_sweep(w, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL pre_echo_byte%0d: got %0h need %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int w[N_CH];
    for (int it = 0; it < 2; it++) begin
      do_reset();
      resp_dly = $urandom_range(20, 1);
      for (int c = 0; c < N_CH; c++)
        w[c] = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(2500, 100);
      run_sweep(w, 1'b0, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_total++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i])
          $display("FAIL rand%0d_byte%0d: got %0h need %0h", it, i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        else n_pass++;
      end
      n_total++; if (proto_err !== 0) $display("FAIL rand%0d_proto: %0d double strobes, need 0", it, proto_err); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int k;
    int r;
    logic [7:0] e[3];
    do_reset();
    r = (300 > 255) ? 255 : 300;
    e[0] = 8'h00; e[1] = 8'((r >> 8) & 255); e[2] = 8'(r & 255);
    @(negedge clock); s_ligar = 1'b1;
    @(negedge clock); s_ligar = 1'b0;
    k = 0;
    while (s_trigger[0] === 1'b1 && k < 1000) begin @(negedge clock); k++; end
    repeat (10) @(negedge clock);
    s_echo[0] = 1'b1;
    repeat (300) @(negedge clock);
    s_echo[0] = 1'b0;
    k = 0;
    while (sat_q.size() < 3 && k < 2000) begin @(negedge clock); k++; end
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (i >= sat_q.size() || sat_q[i] !== e[i])
        $display("FAIL sat_byte%0d: got %0h need %0h", i, (i < sat_q.size()) ? sat_q[i] : 8'hxx, e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int nb;
    do_reset();
    resp_dly = 10;
    pulse_ligar();
    for (int c = 0; c < N_CH; c++) serve_channel(c, 300, 1'b0, 1'b0);
    k = 0;
    while (!(db_estado === 4'd7 && db_canal === 3'd2) && k < 20000) begin
      @(negedge clock);
      k++;
    end
    n_total++;
    if (k >= 20000) $display("FAIL mid_wait: never reached ESPERA_H on channel 2");
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if ({trigger, tx_partida, tx_dado, varrendo, db_estado, db_canal} !== '0)
      $display("FAIL mid_reset_outputs: trig=%0h part=%0b dado=%0h varr=%0b est=%0d can=%0d need all 0",
               trigger, tx_partida, tx_dado, varrendo, db_estado, db_canal);
    else n_pass++;
    reset = 1'b1;
    nb = got_q.size();
    repeat (200) @(negedge clock);
    n_total++; if (got_q.size() !== nb) $display("FAIL mid_no_strobe: got %0d new bytes need 0", got_q.size() - nb); else n_pass++;
    pulse_ligar();
    n_total++;
    if (db_estado !== 4'd1 || db_canal !== 3'd0 || trigger !== 3'b001)
      $display("FAIL mid_restart: est=%0d can=%0d trig=%0h need 1/0/1", db_estado, db_canal, trigger);
    else n_pass++;
  endtask

  task automatic test_pause();
    int w[N_CH] = '{150, 250, 350};
    int k;
    do_reset();
    resp_dly = 4;
    run_sweep(w, 1'b0, -1);
    k = 0;
    while (tx_pronto !== 1'b1 && k < 100) begin @(negedge clock); k++; end
    @(posedge clock);
    k = 0;
`ifdef ROBERTO_SCAN_CONTINUO_EN
    do begin
      @(posedge clock); #1;
      k++;
    end while (trigger[0] !== 1'b1 && k < 400);
    n_total++; if (k !== PAUSE + 1) $display("FAIL pause_restart: trigger[0] after %0d clocks need %0d", k, PAUSE + 1); else n_pass++;
`else
    do begin
      @(posedge clock); #1;
      k++;
    end while (varrendo !== 1'b0 && k < 50);
    n_total++; if (k !== 2) $display("FAIL pause_single: varrendo fell after %0d clocks need 2", k); else n_pass++;
    repeat (50) @(negedge clock);
    n_total++; if (varrendo !== 1'b0) $display("FAIL pause_idle: varrendo=%0b need 0", varrendo); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_sweep_fixed();
    test_timeout();
    test_ligar_in_mede();
    test_echo_pre();
    test_random();
    test_saturation();
    test_reset_mid();
    test_pause();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/roberto_scan.md
ROBERTO_SCAN -- requirements
Module: roberto_scan

Interface
REQ-001 The block SHALL have parameter N_CH, default 3, number of ultrasonic channels (1..8).
REQ-002 The block SHALL have parameter MW, default 16, echo-width measurement bits (8..16).
REQ-003 The block SHALL have parameter TRIG_CYC, default 500, trigger pulse length in clocks.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1500000, per-phase echo timeout in clocks.
REQ-005 The block SHALL have parameter PAUSE_CYC, default 2500000, inter-sweep gap in clocks.
REQ-006 The block SHALL have port clock, input, 1, the single system clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-008 The block SHALL have port ligar, input, 1, start pulse, one clock wide, already edge-detected upstream.
REQ-009 The block SHALL have port echo, input, N_CH, asynchronous sensor echo lines.
REQ-010 The block SHALL have port trigger, output, N_CH, sensor trigger pulses.
REQ-011 The block SHALL have port tx_dado, output, 8, byte for the serial transmitter.
REQ-012 The block SHALL have port tx_partida, output, 1, one-clock start strobe to the transmitter.
REQ-013 The block SHALL have port tx_pronto, input, 1, one-clock transmitter done strobe.
REQ-014 The block SHALL have port varrendo, output, 1, high while a sweep is active.
REQ-015 The block SHALL have port db_estado, output, 4, current FSM state code.
REQ-016 The block SHALL have port db_canal, output, 3, channel under service.

Function
REQ-017 echo SHALL pass a 2-flop synchroniser; all echo timing is measured on the synchronised copy.
REQ-018 The FSM SHALL have states INICIAL(0), DISPARA(1), ESPERA_ECO(2), MEDE(3), ENVIA_ID(4), ESPERA_ID(5), ENVIA_H(6), ESPERA_H(7), ENVIA_L(8), ESPERA_L(9), PROXIMO(10), PAUSA(11).
REQ-019 INICIAL -> DISPARA on ligar=1 with db_canal=0; ligar is ignored in every other state.
REQ-020 DISPARA SHALL drive trigger[db_canal]=1 for exactly TRIG_CYC clocks, all other trigger bits 0, then go to ESPERA_ECO.
REQ-021 ESPERA_ECO -> MEDE on echo rising; after TIMEOUT_CYC clocks without rising, the result SHALL be all-ones with timeout flag set, -> ENVIA_ID.
REQ-022 MEDE SHALL count clocks while echo high; on falling edge -> ENVIA_ID with count stored; count saturates at 2^MW-1; echo high for TIMEOUT_CYC clocks stores all-ones with timeout flag set.
REQ-023 Each channel SHALL send 3 bytes: {timeout flag, 4'b0, channel[2:0]}, result[15:8], result[7:0], with result zero-extended to 16 bits.
REQ-024 ENVIA_* states SHALL last one clock with tx_partida=1 and tx_dado valid; ESPERA_* states SHALL hold tx_dado until tx_pronto=1; tx_pronto outside ESPERA_* is ignored.
REQ-025 PROXIMO SHALL increment db_canal and -> DISPARA if more channels remain, else -> PAUSA with db_canal=0.
REQ-026 varrendo SHALL be 1 in every state except INICIAL.
REQ-027 tx_partida SHALL never be asserted twice without an intervening tx_pronto.
REQ-028 A channel whose echo is already high at DISPARA exit SHALL have rising edge awaited (no edge = timeout).

Reset
REQ-029 reset=0 at a clock edge SHALL force INICIAL, trigger=0, tx_partida=0, tx_dado=0, varrendo=0, db_canal=0, all counters and the synchroniser cleared, regardless of state.
REQ-030 A reset mid-byte SHALL abandon the sweep; no further tx_partida until a new ligar.

Configuration
REQ-031 With ROBERTO_SCAN_CONTINUO_EN defined, PAUSA SHALL last PAUSE_CYC clocks then -> DISPARA on channel 0, repeating indefinitely.
REQ-032 Without ROBERTO_SCAN_CONTINUO_EN, PAUSA SHALL last one clock then -> INICIAL, one sweep per ligar.

Verification
REQ-033 N_CH=3, echo widths 1000/2000/3000 clocks, tx_pronto 10 clocks after each strobe -> 9 bytes 00,03,E8,01,07,D0,02,0B,B8.
REQ-034 Channel 1 never echoes, TIMEOUT_CYC=5000 -> bytes 81,FF,FF after 5000 clocks in ESPERA_ECO; channels 0 and 2 unaffected.
REQ-035 MW=8, echo width 300 -> result bytes 00,FF (saturated, flag clear).
REQ-036 reset=0 during ESPERA_H of channel 2 -> next clock all outputs at reset values; ligar restarts from channel 0.
REQ-037 ligar pulsed during MEDE -> no effect; trigger pulse measured exactly TRIG_CYC clocks on the correct bit only.
REQ-038 With ROBERTO_SCAN_CONTINUO_EN, PAUSE_CYC=100 -> second sweep trigger[0] rises 101 clocks after last tx_pronto; without it, varrendo falls after that tx_pronto.
